// File: rtl/equalize_hist_mul_pipe.sv
// Pipelined unsigned product unit for histogram equalisation: CDF x (levels-1), rounding
// right-shift and optional saturation, with valid/ready backpressure and collapsing bubbles.
module equalize_hist_mul_pipe #(
  parameter int DIN0_WIDTH = 22,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 29,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int QW   = PW + 1;
  localparam int LAST = NUM_STAGE - 1;
  // One guard bit above the product keeps the rounding add from wrapping.
  localparam logic [QW-1:0] RND_INC =
    (ROUND != 0 && SHIFT > 0) ? (QW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  function automatic logic [QW-1:0] round_shift(input logic [PW-1:0] p);
    logic [QW-1:0] q;
    q = {1'b0, p} + RND_INC;
    return q >> SHIFT;
  endfunction

  function automatic logic overflow(input logic [QW-1:0] r);
    return |r[QW-1:DOUT_WIDTH];
  endfunction

  function automatic logic [DOUT_WIDTH-1:0] saturate(input logic [QW-1:0] r);
    if (SATURATE != 0 && overflow(r)) return '1;
    return r[DOUT_WIDTH-1:0];
  endfunction

  logic [NUM_STAGE-1:0]  v_q, v_d, adv;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         fin_p;
  logic                  fin_v;
  logic [QW-1:0]         fin_r;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;

  // A stage may advance when it is empty or everything downstream of it can move.
  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_adv
    assign adv[k] = out_ready || !(&v_q[LAST:k]);
  end

  assign in_ready = adv[0];

  always_comb begin
    v_d = v_q;
    if (adv[0]) v_d[0] = in_valid;
    for (int k = 1; k < NUM_STAGE; k++) begin
      if (adv[k]) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) v_q <= '0;
    else        v_q <= v_d;
  end

  // ---- stage 0 .. NUM_STAGE-2: exact product, carried unchanged ----
  assign prod = PW'(din0) * PW'(din1);

  if (NUM_STAGE == 1) begin : g_direct
    assign fin_p = prod;
    assign fin_v = in_valid;
  end else begin : g_pipe
    logic [PW-1:0] prod_q [NUM_STAGE-1];

    always_ff @(posedge ap_clk) begin
      if (adv[0] && in_valid) prod_q[0] <= prod;
      for (int k = 1; k < NUM_STAGE - 1; k++) begin
        if (adv[k] && v_q[k-1]) prod_q[k] <= prod_q[k-1];
      end
    end

    assign fin_p = prod_q[NUM_STAGE-2];
    assign fin_v = v_q[NUM_STAGE-2];
  end

  // ---- stage NUM_STAGE-1: round, shift, narrow; registered outputs ----
  assign fin_r  = round_shift(fin_p);
  assign dout_d = saturate(fin_r);
  assign ovf_d  = overflow(fin_r);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv[LAST] && fin_v) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_equalize_hist_mul_pipe.sv
// Bench for equalize_hist_mul_pipe: five configurations share one stimulus stream, each with
// its own in-order scoreboard fed by an arithmetic reference model.
module tb_equalize_hist_mul_pipe;

  localparam int NI = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, out_ready;
  logic [21:0]       din0;
  logic [7:0]        din1;
  logic [NI-1:0]     irdy, ovld, ovfv;
  logic [31:0]       dv [NI];

  always #5 clk = ~clk;

  // 0: defaults  1: >>10 to 8b, round+sat  2: >>10 to 8b, wrap  3: 1 stage  4: 4 stages, 30b out
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int SH = (g == 1 || g == 2) ? 10 : 0;
    localparam int DW = (g == 1 || g == 2) ? 8 : ((g == 4) ? 30 : 29);
    localparam int RN = (g == 1) ? 1 : 0;
    localparam int ST = (g == 1) ? 1 : 0;
    localparam int NS = (g == 3) ? 1 : ((g == 4) ? 4 : 3);
    logic [DW-1:0] d_w;
    equalize_hist_mul_pipe #(
      .DIN0_WIDTH(22), .DIN1_WIDTH(8), .DOUT_WIDTH(DW), .NUM_STAGE(NS),
      .SHIFT(SH), .ROUND(RN), .SATURATE(ST)
    ) u_dut (
      .ap_clk   (clk),
      .ap_rst   (rst),
      .in_valid (in_valid),
      .in_ready (irdy[g]),
      .din0     (din0),
      .din1     (din1),
      .out_valid(ovld[g]),
      .out_ready(out_ready),
      .dout     (d_w),
      .ovf      (ovfv[g])
    );
    assign dv[g] = 32'(d_w);
  end

  function automatic int c_sh(int i); return (i == 1 || i == 2) ? 10 : 0; endfunction
  function automatic int c_dw(int i); return (i == 1 || i == 2) ? 8 : ((i == 4) ? 30 : 29); endfunction
  function automatic int c_rn(int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int c_st(int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int c_ns(int i); return (i == 3) ? 1 : ((i == 4) ? 4 : 3); endfunction

  typedef struct {
    logic [31:0] d;
    logic        o;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sbq [NI][$];
  int          n_vec = 0, n_err = 0, cyc = 0;
  bit          chk_lat = 1'b0;
  logic [31:0] last_d [NI];
  logic        last_o [NI];
  bit          prev_stall [NI];
  logic [31:0] prev_d [NI];
  logic        prev_o [NI];

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact product, optional half-LSB add, shift, then clamp or wrap.
  function automatic exp_t ref_mul(int i, longint unsigned a, longint unsigned b);
    exp_t e;
    longint unsigned q, r, lim;
    q = a * b;
    if (c_rn(i) != 0 && c_sh(i) > 0) q = q + (64'd1 << (c_sh(i) - 1));
    r   = q >> c_sh(i);
    lim = 64'd1 << c_dw(i);
    e.o = (r >= lim);
    e.d = (e.o && c_st(i) != 0) ? 32'(lim - 1) : 32'(r % lim);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic [21:0] rnd_a();
    case ($urandom_range(0, 3))
      0:       return 22'd0;
      1:       return 22'h3FFFFF;
      default: return 22'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rnd_b();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are decided by the values stable before the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        sbq[i].delete();
        prev_stall[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (prev_stall[i]) begin
          check_eq($sformatf("stall_valid%0d", i), ovld[i], 1);
          check_eq($sformatf("stall_dout%0d", i), dv[i], prev_d[i]);
          check_eq($sformatf("stall_ovf%0d", i), ovfv[i], prev_o[i]);
        end
        check_eq($sformatf("in_ready%0d", i), irdy[i],
                 (out_ready || sbq[i].size() < c_ns(i)) ? 1 : 0);
        if (ovld[i] && out_ready) begin
          if (sbq[i].size() == 0) begin
            check_eq($sformatf("spurious%0d", i), ovld[i], 0);
          end else begin
            e = sbq[i].pop_front();
            check_eq($sformatf("dout%0d", i), dv[i], e.d);
            check_eq($sformatf("ovf%0d", i), ovfv[i], e.o);
            if (e.lat) check_eq($sformatf("latency%0d", i), cyc - e.cyc, c_ns(i));
            last_d[i] = dv[i];
            last_o[i] = ovfv[i];
          end
        end
        if (in_valid && irdy[i]) begin
          e     = ref_mul(i, din0, din1);
          e.cyc = cyc;
          e.lat = chk_lat && out_ready;
          sbq[i].push_back(e);
        end
        prev_stall[i] = ovld[i] && !out_ready;
        prev_d[i]     = dv[i];
        prev_o[i]     = ovfv[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    step();
    in_valid = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
    repeat (2) step();
    check_eq("rst_valid", ovld, 0);
    check_eq("rst_ovf", ovfv, 0);
    for (int i = 0; i < NI; i++) check_eq($sformatf("rst_dout%0d", i), dv[i], 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("ready_after_rst", irdy, 5'b11111);

    // Directed operands with exact latency checking
    chk_lat = 1'b1;
    send(22'd100000, 8'd255);
    check_eq("def_100k_dout", last_d[0], 25500000);
    check_eq("def_100k_ovf", last_o[0], 0);
    send(22'd4194303, 8'd255);
    check_eq("def_max_dout", last_d[0], 532676353);
    check_eq("def_max_ovf", last_o[0], 1);
    check_eq("w30_max_dout", last_d[4], 1069547265);
    check_eq("w30_max_ovf", last_o[4], 0);
    send(22'd1000, 8'd255);
    check_eq("sat_1000_dout", last_d[1], 249);
    check_eq("sat_1000_ovf", last_o[1], 0);
    send(22'd2000, 8'd255);
    check_eq("sat_2000_dout", last_d[1], 255);
    check_eq("sat_2000_ovf", last_o[1], 1);
    check_eq("wrap_2000_dout", last_d[2], 242);
    check_eq("wrap_2000_ovf", last_o[2], 1);
    send(22'd3, 8'd255);
    check_eq("sat_3_dout", last_d[1], 1);
    check_eq("wrap_3_dout", last_d[2], 0);
    send(22'd2, 8'd255);
    check_eq("sat_2_dout", last_d[1], 0);
    send(22'd0, 8'd255);
    check_eq("zero_a_dout", last_d[0], 0);
    check_eq("zero_a_ovf", last_o[0], 0);
    send(22'd123, 8'd0);
    check_eq("zero_b_dout", last_d[0], 0);

    // Fill the pipes under stall, then reset asynchronously between edges
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din0 = rnd_a(); din1 = rnd_b();
      step();
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_valid", ovld, 0);
    check_eq("midrst_ovf", ovfv, 0);
    for (int i = 0; i < NI; i++) check_eq($sformatf("midrst_dout%0d", i), dv[i], 0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    send(22'd4321, 8'd77);
    check_eq("post_rst_dout", last_d[0], 332717);

    // Back-to-back stream: latency check on every item implies no bubbles
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; din0 = rnd_a(); din1 = rnd_b();
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();

    // Random valid/ready toggling
    chk_lat = 1'b0;
    for (int k = 0; k < 200; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      din0 = rnd_a();
      din1 = rnd_b();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    for (int i = 0; i < NI; i++) check_eq($sformatf("drain%0d", i), sbq[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
